dcache_sa: RTL and testbench
============================

Name: dcache_sa

Overview:
- Parametrised set-associative successor to the direct-mapped data cache.
- Configurable sets, ways and line length; write-through, no-write-allocate.
- Cacheable read misses trigger a multi-beat line refill; a high-address region bypasses the cache.
- Sits between the load/store unit (single read and write port with miss tags) and the strobe/ack memory bus.

Parameters:
NUM_SETS, 16, sets (power of 2)
NUM_WAYS, 2, ways per set (power of 2, 1..8)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)
TAG_W, 4, width of requester tags
UNCACHED_BASE, 32'hF000_0000, addresses >= this are non-cacheable

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
read_addr_1  in  32  load byte address
read_tag_1  in  TAG_W  load tag
read_valid_1  in  1  load request
read_ready_1  out  1  load accept
read_data_out_1  out  32  load data, valid with read_hit_1
read_hit_1  out  1  load completed
read_miss_1  out  1  load missed, must be replayed
read_miss_tag_1  out  TAG_W  tag of missed load
write_addr_1  in  32  store address
write_data_1  in  32  store data, LSB-aligned
write_size_1  in  2  0 byte, 1 half, 2/3 word
write_tag_1  in  TAG_W  store tag
write_valid_1  in  1  store request
write_ready_1  out  1  store accept
write_hit_1  out  1  store updated cache
write_miss_1  out  1  store went to memory only
write_miss_tag_1  out  TAG_W  tag of missed store
bus_addr_read  out  32  read address (word aligned)
bus_data_read  in  32  read data
bus_stbr  out  1  read strobe
bus_ackr  in  1  read acknowledge
bus_addr_write  out  32  write address (word aligned)
bus_data_write  out  32  lane-positioned write data
bus_sel_write  out  4  byte enables
bus_stbw  out  1  write strobe
bus_ackw  in  1  write acknowledge

Behaviour:
- Reset (reset=0, async): all valid bits, RR pointers, FSM->IDLE, one-entry write buffer empty; every output 0 except ready signals, which rise after reset release. Reset mid-refill aborts it; no partial line becomes valid.
- Acceptance: request taken on the edge where valid&&ready. read_ready_1 = (state==IDLE) && !write_valid_1. write_ready_1 = (state==IDLE) && write buffer empty. A simultaneous store wins.
- Address split: [1:0] byte, then log2(WORDS_PER_LINE) word index, log2(NUM_SETS) set index, remaining bits tag.
- FSM states: IDLE, LOOKUP, REFILL, UNC_RD.
  - IDLE -> LOOKUP on acceptance.
  - LOOKUP compares all ways. All hit/miss outputs are registered, pulse exactly one cycle, and assert on the edge after the LOOKUP cycle (acceptance edge +1).
- Read hit: read_hit_1=1, read_data_out_1=word; LOOKUP -> IDLE.
- Read miss (cacheable): read_miss_1=1, miss_tag=read tag; LOOKUP -> REFILL.
  - Victim selection: lowest-index invalid way, else per-set round-robin pointer, which then increments mod NUM_WAYS.
  - REFILL waits until the write buffer is empty.
  - It then issues WORDS_PER_LINE beats from the line base, ascending.
  - Each beat holds bus_stbr=1 until the edge with bus_ackr=1 and captures data there. bus_stbr=0 for the following cycle before the next beat.
  - Tag and valid are written only after the last beat; then -> IDLE. No data is returned, and the requester replays.
- Read uncached: LOOKUP -> UNC_RD (after write buffer drains).
  - One beat to the aligned address; on ack, read_hit_1=1 with bus data; -> IDLE. No cache state changes.
- Store: always enters the write buffer in LOOKUP.
  - Cacheable hit: byte lanes merged into the line; write_hit_1.
  - Miss or uncached: write_miss_1, tag=write tag; no allocation.
- Lane alignment: half-word ignores addr[0], word ignores addr[1:0]. bus_sel_write is 0001<<a, 0011<<a or 1111.
- Write buffer: drives bus_stbw=1 until bus_ackw=1, then empties the next cycle. It drains concurrently with reads and hits.
- A load after a store to the same word sees the new data (array updated in LOOKUP).

Optional Feature:
- Macro DCACHE_SA_PERF_CNT_EN.
- Defined: adds outputs perf_read_hits, perf_read_misses, perf_write_hits, perf_write_misses (32 bits each). Each increments with the matching pulse, wraps at 2^32, and clears on reset.
- Undefined: ports and counters absent.

Decomposition:
- Package dcache_sa_pkg: FSM state enum, write-size codes, index/offset width constants derived by function from the parameters, and a byte-enable generation function.
- Sub-module dcache_sa_way: one way's valid/tag/data arrays with read, tag compare, byte-enable write and line-fill ports. Instantiate it NUM_WAYS times.

Test Plan:
- Memory word i = i*32'h1111_1111. Read 0x0 -> read_miss_1, 4 read beats at 0x0..0xC. Replay reads 0x4, 0x8 -> read_hit_1 with 1111_1111, 2222_2222.
- Word store F0F0_F0F0 to 0x0 then read 0x0 -> write_hit_1, bus_sel_write=1111, read returns F0F0_F0F0. Byte store 0xAB to 0x5 -> bus_sel_write=0010, subsequent read 0x4 returns 1111_AB11.
- Fill 3 lines mapping to set 0 (0x0, 0x100, 0x200; NUM_SETS=16, 2 ways) -> third refill evicts way 0, and re-reading 0x0 misses.
- Store to 0xFFFF_1000 -> write_miss_1, bus_stbw held until ackw, no cache change. Read 0xFFFF_2000 -> single beat, read_hit_1 with bus data.
- Reset asserted during the second refill beat -> outputs 0, FSM idle, and a replayed read misses.
- Simultaneous read and write valid -> store accepted first and read_ready_1=0 that cycle; both tags are reported in order.

Source files
------------

// File: rtl/dcache_sa_pkg.sv
// dcache_sa_pkg: shared types, size codes and helpers for the dcache_sa cache.
package dcache_sa_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, UNC_RD} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    function automatic int log2i(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? 4'b0001 << a :
               size == SZ_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction

endpackage

// File: rtl/dcache_sa_way.sv
// dcache_sa_way: one way of the cache - valid bits, tags and line data with
// byte-enable store merge and word-by-word line fill.
module dcache_sa_way
    import dcache_sa_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int LTAG_W         = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [log2i(NUM_SETS)-1:0]        set,
    input  logic [log2i(WORDS_PER_LINE)-1:0]  word,
    input  logic [LTAG_W-1:0]                 tag,
    output logic                              hit,
    output logic                              valid,
    output logic [31:0]                       rdata,
    input  logic                              wr_en,
    input  logic [3:0]                        wr_be,
    input  logic [31:0]                       wr_data,
    input  logic                              fill_en,
    input  logic                              fill_last,
    input  logic [31:0]                       fill_data
);

    logic [NUM_SETS-1:0] valids;
    logic [LTAG_W-1:0]   tags [NUM_SETS];
    logic [31:0]         mem  [NUM_SETS*WORDS_PER_LINE];

    assign valid = valids[set];
    assign hit   = valid && tags[set] == tag;
    assign rdata = mem[{set, word}];

    always_ff @(posedge clk or negedge reset)
        if (!reset) valids <= '0;
        else if (fill_en && fill_last) valids[set] <= 1'b1;

    always_ff @(posedge clk)
        if (fill_en && fill_last) tags[set] <= tag;

    always_ff @(posedge clk)
        if (fill_en) mem[{set, word}] <= fill_data;
        else if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[{set, word}][8*b +: 8] <= wr_data[8*b +: 8];

endmodule

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative write-through, no-write-allocate data cache with line refill
// and an uncached high region. Define DCACHE_SA_PERF_CNT_EN for hit/miss performance counters.
module dcache_sa
    import dcache_sa_pkg::*;
#(
    parameter int          NUM_SETS       = 16,
    parameter int          NUM_WAYS       = 2,
    parameter int          WORDS_PER_LINE = 4,
    parameter int          TAG_W          = 4,
    parameter logic [31:0] UNCACHED_BASE  = 32'hF000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      read_addr_1,
    input  logic [TAG_W-1:0] read_tag_1,
    input  logic             read_valid_1,
    output logic             read_ready_1,
    output logic [31:0]      read_data_out_1,
    output logic             read_hit_1,
    output logic             read_miss_1,
    output logic [TAG_W-1:0] read_miss_tag_1,
    input  logic [31:0]      write_addr_1,
    input  logic [31:0]      write_data_1,
    input  logic [1:0]       write_size_1,
    input  logic [TAG_W-1:0] write_tag_1,
    input  logic             write_valid_1,
    output logic             write_ready_1,
    output logic             write_hit_1,
    output logic             write_miss_1,
    output logic [TAG_W-1:0] write_miss_tag_1,
    output logic [31:0]      bus_addr_read,
    input  logic [31:0]      bus_data_read,
    output logic             bus_stbr,
    input  logic             bus_ackr,
    output logic [31:0]      bus_addr_write,
    output logic [31:0]      bus_data_write,
    output logic [3:0]       bus_sel_write,
    output logic             bus_stbw,
    input  logic             bus_ackw
`ifdef DCACHE_SA_PERF_CNT_EN
    ,
    output logic [31:0]      perf_read_hits,
    output logic [31:0]      perf_read_misses,
    output logic [31:0]      perf_write_hits,
    output logic [31:0]      perf_write_misses
`endif
);

    localparam int WORD_W = log2i(WORDS_PER_LINE);
    localparam int SET_W  = log2i(NUM_SETS);
    localparam int LTAG_W = 30 - WORD_W - SET_W;
    localparam int WAY_W  = NUM_WAYS > 1 ? log2i(NUM_WAYS) : 1;

    state_t            state;
    logic              req_wr;
    logic [31:0]       req_addr, req_data;
    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        req_size;
    logic [WORD_W-1:0] beat, idx_word;
    logic [WAY_W-1:0]  victim, pick;
    logic [WAY_W-1:0]  rr [NUM_SETS];
    logic              wb_valid;
    logic [NUM_WAYS-1:0] way_hit, way_valid;
    logic [31:0]       way_data [NUM_WAYS];
    logic [31:0]       hit_data, wdata_rep;
    logic              hit, has_inv, uncached, fill_ack;
    logic [3:0]        be;
    logic [SET_W-1:0]  req_set;
    logic [LTAG_W-1:0] req_ltag;

    assign req_set   = req_addr[2+WORD_W +: SET_W];
    assign req_ltag  = req_addr[31 -: LTAG_W];
    assign idx_word  = state == REFILL ? beat : req_addr[2 +: WORD_W];
    assign uncached  = req_addr >= UNCACHED_BASE;
    assign hit       = |way_hit && !uncached;
    assign be        = byte_en(req_size, req_addr[1:0]);
    assign wdata_rep = req_size == SZ_BYTE ? {4{req_data[7:0]}} :
                       req_size == SZ_HALF ? {2{req_data[15:0]}} : req_data;
    assign fill_ack  = state == REFILL && bus_stbr && bus_ackr;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        dcache_sa_way #(
            .NUM_SETS(NUM_SETS), .WORDS_PER_LINE(WORDS_PER_LINE), .LTAG_W(LTAG_W)
        ) u_way (
            .clk(clk), .reset(reset), .set(req_set), .word(idx_word), .tag(req_ltag),
            .hit(way_hit[g]), .valid(way_valid[g]), .rdata(way_data[g]),
            .wr_en(state == LOOKUP && req_wr && !uncached && way_hit[g]),
            .wr_be(be), .wr_data(wdata_rep),
            .fill_en(fill_ack && victim == WAY_W'(g)), .fill_last(&beat),
            .fill_data(bus_data_read)
        );
    end

    // Descending scan so the lowest-index invalid way is the last one picked.
    always_comb begin
        hit_data = '0;
        pick     = rr[req_set];
        has_inv  = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_data = hit_data | (way_hit[w] ? way_data[w] : 32'd0);
            if (!way_valid[w]) begin
                pick    = WAY_W'(w);
                has_inv = 1'b1;
            end
        end
    end

    assign read_ready_1   = reset && state == IDLE && !write_valid_1;
    assign write_ready_1  = reset && state == IDLE && !wb_valid;
    assign bus_stbw       = wb_valid;
    assign bus_addr_read  = state == UNC_RD ? {req_addr[31:2], 2'b00}
                                            : {req_addr[31:2+WORD_W], beat, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            req_wr           <= 1'b0;
            req_addr         <= '0;
            req_data         <= '0;
            req_tag          <= '0;
            req_size         <= '0;
            beat             <= '0;
            victim           <= '0;
            for (int s = 0; s < NUM_SETS; s++) rr[s] <= '0;
            wb_valid         <= 1'b0;
            bus_addr_write   <= '0;
            bus_data_write   <= '0;
            bus_sel_write    <= '0;
            bus_stbr         <= 1'b0;
            read_data_out_1  <= '0;
            read_hit_1       <= 1'b0;
            read_miss_1      <= 1'b0;
            read_miss_tag_1  <= '0;
            write_hit_1      <= 1'b0;
            write_miss_1     <= 1'b0;
            write_miss_tag_1 <= '0;
        end else begin
            read_hit_1   <= 1'b0;
            read_miss_1  <= 1'b0;
            write_hit_1  <= 1'b0;
            write_miss_1 <= 1'b0;
            if (wb_valid && bus_ackw) wb_valid <= 1'b0;
            case (state)
                IDLE:
                    if (write_valid_1 && write_ready_1) begin
                        req_wr   <= 1'b1;
                        req_addr <= write_addr_1;
                        req_data <= write_data_1;
                        req_size <= write_size_1;
                        req_tag  <= write_tag_1;
                        state    <= LOOKUP;
                    end else if (read_valid_1 && read_ready_1) begin
                        req_wr   <= 1'b0;
                        req_addr <= read_addr_1;
                        req_tag  <= read_tag_1;
                        state    <= LOOKUP;
                    end
                LOOKUP:
                    if (req_wr) begin
                        wb_valid       <= 1'b1;
                        bus_addr_write <= {req_addr[31:2], 2'b00};
                        bus_data_write <= wdata_rep;
                        bus_sel_write  <= be;
                        write_hit_1    <= hit;
                        write_miss_1   <= !hit;
                        if (!hit) write_miss_tag_1 <= req_tag;
                        state          <= IDLE;
                    end else if (uncached) begin
                        state <= UNC_RD;
                    end else if (hit) begin
                        read_hit_1      <= 1'b1;
                        read_data_out_1 <= hit_data;
                        state           <= IDLE;
                    end else begin
                        read_miss_1     <= 1'b1;
                        read_miss_tag_1 <= req_tag;
                        victim          <= pick;
                        if (!has_inv)
                            rr[req_set] <= rr[req_set] == WAY_W'(NUM_WAYS - 1) ? '0 : rr[req_set] + 1'b1;
                        beat            <= '0;
                        state           <= REFILL;
                    end
                default:
                    if (bus_stbr && bus_ackr) begin
                        bus_stbr <= 1'b0;
                        beat     <= beat + 1'b1;
                        if (state == UNC_RD) begin
                            read_hit_1      <= 1'b1;
                            read_data_out_1 <= bus_data_read;
                            state           <= IDLE;
                        end else if (&beat) begin
                            state <= IDLE;
                        end
                    end else if (!bus_stbr && !wb_valid) begin
                        bus_stbr <= 1'b1;
                    end
            endcase
        end
    end

`ifdef DCACHE_SA_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_read_hits    <= '0;
            perf_read_misses  <= '0;
            perf_write_hits   <= '0;
            perf_write_misses <= '0;
        end else begin
            perf_read_hits    <= perf_read_hits + {31'd0, read_hit_1};
            perf_read_misses  <= perf_read_misses + {31'd0, read_miss_1};
            perf_write_hits   <= perf_write_hits + {31'd0, write_hit_1};
            perf_write_misses <= perf_write_misses + {31'd0, write_miss_1};
        end
    end
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed self-checking bench for dcache_sa with bus responders
// that return word i = i*32'h1111_1111 (uncached region: 32'hCAFE_0000 ^ addr).
module tb_dcache_sa;

    logic        clk = 0;
    logic        reset;
    logic [31:0] read_addr_1, read_data_out_1, write_addr_1, write_data_1;
    logic [3:0]  read_tag_1, read_miss_tag_1, write_tag_1, write_miss_tag_1;
    logic        read_valid_1, read_ready_1, read_hit_1, read_miss_1;
    logic [1:0]  write_size_1;
    logic        write_valid_1, write_ready_1, write_hit_1, write_miss_1;
    logic [31:0] bus_addr_read, bus_data_read, bus_addr_write, bus_data_write;
    logic        bus_stbr, bus_ackr, bus_stbw, bus_ackw;
    logic [3:0]  bus_sel_write;

    dcache_sa dut (
        .clk(clk), .reset(reset),
        .read_addr_1(read_addr_1), .read_tag_1(read_tag_1), .read_valid_1(read_valid_1),
        .read_ready_1(read_ready_1), .read_data_out_1(read_data_out_1), .read_hit_1(read_hit_1),
        .read_miss_1(read_miss_1), .read_miss_tag_1(read_miss_tag_1),
        .write_addr_1(write_addr_1), .write_data_1(write_data_1), .write_size_1(write_size_1),
        .write_tag_1(write_tag_1), .write_valid_1(write_valid_1), .write_ready_1(write_ready_1),
        .write_hit_1(write_hit_1), .write_miss_1(write_miss_1), .write_miss_tag_1(write_miss_tag_1),
        .bus_addr_read(bus_addr_read), .bus_data_read(bus_data_read), .bus_stbr(bus_stbr),
        .bus_ackr(bus_ackr), .bus_addr_write(bus_addr_write), .bus_data_write(bus_data_write),
        .bus_sel_write(bus_sel_write), .bus_stbw(bus_stbw), .bus_ackw(bus_ackw)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gap_err = 0, wcnt = 0, cyc = 0, nwrites = 0;
    int wm_cyc = 0, rm_cyc = 0, lat = 0, base = 0;
    logic [3:0]  wm_tag, rm_tag;
    logic        resp_en = 1;
    logic [31:0] rd_q[$];
    logic [31:0] w_addr, w_data;
    logic [3:0]  w_sel;
    logic        r_hit, r_miss, w_hit, w_miss;
    logic [31:0] r_data;
    logic [3:0]  r_mtag, w_mtag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >= 32'hF000_0000 ? (32'hCAFE_0000 ^ a) : (a >> 2) * 32'h1111_1111;
    endfunction

    initial begin
        bus_ackr = 0;
        bus_data_read = 0;
        forever begin
            @(negedge clk);
            if (bus_ackr) begin
                bus_ackr = 0;
                if (bus_stbr) gap_err++;
            end else if (bus_stbr && resp_en) begin
                bus_ackr = 1;
                bus_data_read = mem_word(bus_addr_read);
                rd_q.push_back(bus_addr_read);
            end
        end
    end

    initial begin
        bus_ackw = 0;
        forever begin
            @(negedge clk);
            if (bus_ackw) bus_ackw = 0;
            else if (bus_stbw) begin
                wcnt++;
                if (wcnt == 3) begin
                    bus_ackw = 1;
                    wcnt = 0;
                    w_addr = bus_addr_write;
                    w_data = bus_data_write;
                    w_sel = bus_sel_write;
                    nwrites++;
                end
            end else wcnt = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (write_miss_1) begin wm_cyc = cyc; wm_tag = write_miss_tag_1; end
        if (read_miss_1) begin rm_cyc = cyc; rm_tag = read_miss_tag_1; end
    end

    task automatic wait_idle();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (read_ready_1 && write_ready_1) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] t);
        read_addr_1 = a;
        read_tag_1 = t;
        read_valid_1 = 1;
        for (int n = 0; n < 200 && !read_ready_1; n++) @(negedge clk);
        if (!read_ready_1) check("rd_accept", 0, 1);
        @(posedge clk);
        #1 read_valid_1 = 0;
        r_hit = 0; r_miss = 0; lat = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (read_hit_1 || read_miss_1) begin
                r_hit = read_hit_1; r_miss = read_miss_1;
                r_data = read_data_out_1; r_mtag = read_miss_tag_1;
                lat = n;
                break;
            end
        end
        if (lat == 0) check("rd_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input logic [3:0] t);
        write_addr_1 = a;
        write_data_1 = d;
        write_size_1 = s;
        write_tag_1 = t;
        write_valid_1 = 1;
        for (int n = 0; n < 200 && !write_ready_1; n++) @(negedge clk);
        if (!write_ready_1) check("wr_accept", 0, 1);
        @(posedge clk);
        #1 write_valid_1 = 0;
        w_hit = 0; w_miss = 0; lat = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (write_hit_1 || write_miss_1) begin
                w_hit = write_hit_1; w_miss = write_miss_1; w_mtag = write_miss_tag_1;
                lat = n;
                break;
            end
        end
        if (lat == 0) check("wr_timeout", 0, 1);
    endtask

    initial begin
        reset = 0;
        read_valid_1 = 0; read_addr_1 = 0; read_tag_1 = 0;
        write_valid_1 = 0; write_addr_1 = 0; write_data_1 = 0; write_size_1 = 0; write_tag_1 = 0;
        repeat (3) @(negedge clk);
        check("rst_read_ready", read_ready_1, 0);
        check("rst_write_ready", write_ready_1, 0);
        check("rst_outputs", {read_hit_1, read_miss_1, write_hit_1, write_miss_1, bus_stbr, bus_stbw}, 0);
        reset = 1;
        @(negedge clk);
        check("rel_ready", {read_ready_1, write_ready_1}, 2'b11);

        // cold miss and 4-beat refill
        do_read(32'h0, 4'd1);
        check("miss0", {r_hit, r_miss}, 2'b01);
        check("miss0_tag", r_mtag, 4'd1);
        check("miss0_lat", lat, 2);
        wait_idle();
        check("refill_beats", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) check("refill_addr", rd_q[i], i * 4);

        do_read(32'h4, 4'd2);
        check("hit4", {r_hit, r_miss}, 2'b10);
        check("hit4_data", r_data, 32'h1111_1111);
        check("hit4_lat", lat, 2);
        @(negedge clk);
        check("hit_pulse_1cyc", read_hit_1, 0);
        do_read(32'h8, 4'd2);
        check("hit8_data", r_data, 32'h2222_2222);

        // word store hit, then byte store hit
        do_write(32'h0, 32'hF0F0_F0F0, 2'd2, 4'd3);
        check("wr0_hit", {w_hit, w_miss}, 2'b10);
        do_read(32'h0, 4'd3);
        check("rd_after_wr", r_data, 32'hF0F0_F0F0);
        wait_idle();
        check("wr0_sel", w_sel, 4'b1111);
        check("wr0_addr", w_addr, 32'h0);
        check("wr0_data", w_data, 32'hF0F0_F0F0);
        do_write(32'h5, 32'h0000_00AB, 2'd0, 4'd4);
        check("wr5_hit", {w_hit, w_miss}, 2'b10);
        wait_idle();
        check("wr5_sel", w_sel, 4'b0010);
        check("wr5_lane", w_data[15:8], 8'hAB);
        check("wr5_addr", w_addr, 32'h4);
        do_read(32'h4, 4'd5);
        check("rd4_merged", r_data, 32'h1111_AB11);

        // three lines into set 0: third refill evicts way 0
        do_read(32'h100, 4'd6);
        check("miss100", r_miss, 1);
        wait_idle();
        do_read(32'h200, 4'd6);
        check("miss200", r_miss, 1);
        wait_idle();
        do_read(32'h100, 4'd6);
        check("hit100", {r_hit, r_miss}, 2'b10);
        check("hit100_data", r_data, 32'h4444_4440);
        do_read(32'h0, 4'd7);
        check("evicted0_miss", {r_hit, r_miss}, 2'b01);
        wait_idle();
        do_read(32'h200, 4'd7);
        check("hit200_data", r_data, 32'h8888_8880);

        // uncached store and read
        base = nwrites;
        do_write(32'hFFFF_1000, 32'h1234_5678, 2'd2, 4'd5);
        check("unc_wr_miss", {w_hit, w_miss}, 2'b01);
        check("unc_wr_tag", w_mtag, 4'd5);
        check("stbw_held", {bus_stbw, bus_ackw}, 2'b10);
        wait_idle();
        check("unc_wr_count", nwrites - base, 1);
        check("unc_wr_addr", w_addr, 32'hFFFF_1000);
        check("unc_wr_data", w_data, 32'h1234_5678);
        base = rd_q.size();
        do_read(32'hFFFF_2000, 4'd6);
        check("unc_rd_hit", {r_hit, r_miss}, 2'b10);
        check("unc_rd_data", r_data, 32'h3501_2000);
        check("unc_rd_beats", rd_q.size() - base, 1);
        check("unc_rd_addr", rd_q[rd_q.size()-1], 32'hFFFF_2000);
        do_read(32'h200, 4'd6);
        check("unc_no_change", {r_hit, r_data}, {1'b1, 32'h8888_8880});

        // reset during the second refill beat
        base = rd_q.size();
        do_read(32'h300, 4'd8);
        check("miss300", r_miss, 1);
        for (int n = 0; n < 100 && rd_q.size() < base + 1; n++) @(negedge clk);
        resp_en = 0;
        for (int n = 0; n < 100 && !bus_stbr; n++) @(negedge clk);
        check("beat2_strobe", bus_stbr, 1);
        reset = 0;
        @(negedge clk);
        check("midrst_outputs", {bus_stbr, bus_stbw, read_hit_1, read_miss_1, read_ready_1}, 0);
        reset = 1;
        resp_en = 1;
        @(negedge clk);
        check("midrst_idle", {read_ready_1, write_ready_1}, 2'b11);
        do_read(32'h200, 4'd9);
        check("after_rst_miss", {r_hit, r_miss}, 2'b01);
        wait_idle();

        // simultaneous store and load: store first
        read_addr_1 = 32'h4; read_tag_1 = 4'd7; read_valid_1 = 1;
        write_addr_1 = 32'h8; write_data_1 = 32'h55; write_size_1 = 2'd2;
        write_tag_1 = 4'd8; write_valid_1 = 1;
        #1 check("simul_ready", {read_ready_1, write_ready_1}, 2'b01);
        @(posedge clk);
        #1 write_valid_1 = 0;
        for (int n = 0; n < 50 && !read_ready_1; n++) @(negedge clk);
        @(posedge clk);
        #1 read_valid_1 = 0;
        wait_idle();
        check("simul_wtag", wm_tag, 4'd8);
        check("simul_rtag", rm_tag, 4'd7);
        check("simul_order", wm_cyc < rm_cyc, 1);
        check("stbr_gap", gap_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
